// File: rtl/shift_add_mult.sv
// Sequential unsigned N x N shift-and-add multiplier with a start/busy/done handshake.
// Each RUN cycle performs one N-bit add with carry-out, then shifts {carry, sum, Q} right by one.
module shift_add_mult #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] p
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [N-1:0]     r_m;
   logic [N-1:0]     r_a;
   logic [N-1:0]     r_q;
   logic [CW-1:0]    r_cnt;
   logic [2*N-1:0]   r_p;
   logic             r_busy;
   logic             r_done;

   logic [N-1:0]     w_addend;
   logic [N:0]       w_sum;
   logic [N-1:0]     w_a_next;
   logic [N-1:0]     w_q_next;
   logic             w_last;
   logic             w_load;
   logic             w_step;
   logic             w_finish;

   // One iteration: the carry-out lands in A's MSB, so (2^N-1)^2 never overflows.
   always_comb begin
      w_addend = r_q[0] ? r_m : {N{1'b0}};
      w_sum    = {1'b0, r_a} + {1'b0, w_addend};
      w_a_next = w_sum[N:1];
      w_q_next = {w_sum[0], r_q[N-1:1]};
      w_last   = (r_cnt == CW'(N - 1));
   end

   // Next-state and datapath control decode.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_RUN;
               w_load       = 1'b1;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_RUN: begin
            w_step = 1'b1;
            if (w_last) begin
               w_state_next = S_DONE;
               w_finish     = 1'b1;
            end else begin
               w_state_next = S_RUN;
            end
         end
         S_DONE: begin
            if (start) begin
               w_state_next = S_RUN;
               w_load       = 1'b1;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // State register and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_busy  <= (w_state_next == S_RUN);
         r_done  <= (w_state_next == S_DONE);
      end
   end

   // Operand capture and shift-add iteration.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m   <= {N{1'b0}};
         r_a   <= {N{1'b0}};
         r_q   <= {N{1'b0}};
         r_cnt <= {CW{1'b0}};
      end else if (w_load) begin
         r_m   <= a;
         r_a   <= {N{1'b0}};
         r_q   <= b;
         r_cnt <= {CW{1'b0}};
      end else if (w_step) begin
         r_a   <= w_a_next;
         r_q   <= w_q_next;
         r_cnt <= r_cnt + CW'(1);
      end else begin
         r_m   <= r_m;
         r_a   <= r_a;
         r_q   <= r_q;
         r_cnt <= r_cnt;
      end
   end

   // Product register: written only on completion, held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_p <= {(2*N){1'b0}};
      end else if (w_finish) begin
         r_p <= {w_a_next, w_q_next};
      end else begin
         r_p <= r_p;
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign p    = r_p;

endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
Sequential unsigned N×N shift-and-add multiplier. It is the consumer stage for the week-10 N-bit adder. Each iteration issues one N-bit add with carry-out: partial-product high half + multiplicand. It then shifts the {carry, sum, multiplier} register right by one. A start/busy/done handshake lets a controller or testbench launch one multiply and collect a 2N-bit product.

Parameters:
N, 4, operand width in bits (N ≥ 2); product width is 2N; iteration counter width is clog2(N).

Ports:
clk    input   1    rising-edge clock
rst    input   1    synchronous reset, active-high
start  input   1    request a multiply; sampled only in IDLE or DONE
a      input   N    multiplicand, captured on the accepting edge
b      input   N    multiplier, captured on the accepting edge
busy   output  1    high while in RUN
done   output  1    one-cycle pulse; p is valid from this cycle onward
p      output  2N   product register, unsigned a*b

Behaviour:
- Reset (rst=1 at a rising edge): overrides everything, including mid-RUN.
  - State → IDLE.
  - busy=0, done=0, p=0.
  - Internal registers M, A, Q, cnt, carry all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 → load M=a, Q=b, A=0, cnt=0; go to RUN.
  - start=0 → stay in IDLE.
- RUN (busy=1, done=0): one iteration per clock.
  - {c, s} = A + (Q[0] ? M : 0), computed as a full N-bit add; c is the carry-out.
  - {A, Q} ← {c, s, Q} >> 1: c enters the MSB of A, s[0] enters the MSB of Q, Q[0] is discarded.
  - cnt ← cnt+1.
  - After the iteration with cnt==N-1 → go to DONE and load p ← {A_next, Q_next}.
  - start is ignored while in RUN; a, b changes have no effect.
- DONE (lasts one cycle): busy=0, done=1.
  - start=1 → accept exactly as from IDLE; go to RUN. done still drops next cycle.
  - Otherwise → go to IDLE.
- Latency: if start is accepted at edge k, the state is RUN for edges k+1 … k+N. done is high in the cycle after edge k+N, i.e. N+1 cycles after the accepting edge (5 cycles for N=4). Throughput is one product per N+1 cycles with back-to-back starts.
- p is written only on entry to DONE. It holds its value through IDLE and through the next RUN until the next completion.
- Width rules:
  - All arithmetic is unsigned and exact; there is no overflow.
  - The carry-out of each add is kept in the shift, never dropped, so (2^N−1)² is representable.
- busy and done are never high in the same cycle.
- start asserted in the same cycle as rst=1 is ignored.

Test Plan:
- Reset then basic multiply: rst=1 for 2 cycles → busy=0, done=0, p=0. Then a=5, b=3, start pulse → busy high for 4 cycles, done pulses once, p=15 (0x0F).
- Carry path: a=15, b=15 → p=225 (0xE1), done exactly 5 cycles after the accepting edge. a=15, b=1 → p=15. a=8, b=15 → p=120.
- Zero and identity: a=0, b=13 → p=0. a=9, b=0 → p=0. a=1, b=11 → p=11. Checks that p updates even when the result is 0 (previous p must be overwritten).
- Start ignored while busy: launch a=6, b=7, then hold start=1 with a=2, b=2 throughout RUN → p=42. Exactly one done pulse per accepted start.
- Back-to-back: start held high continuously with a=3, b=4 then a=7, b=9 presented at the DONE cycle → p=12, then p=63. done pulses are 5 cycles apart; busy is low only during DONE cycles.
- Reset mid-operation: start a=13, b=11, assert rst on the 2nd RUN cycle → next cycle busy=0, done=0, p=0, and no done pulse follows. A fresh start with a=13, b=11 → p=143.
- Exhaustive sweep: all 256 a,b pairs for N=4, each compared with the a*b reference model.
